conv_enc_framer_k3: RTL and testbench

//  Transmit end of the Viterbi link. Rate-1/2, K=3 convolutional encoder with frame control.
//  - Accepts a serial bit stream with a valid/ready handshake.
//  - Encodes FRAME_LEN data bits per frame, then appends K-1=2 zero tail bits, so the trellis

---
 rtl/conv_enc_framer_k3.sv | 156 +++++++++++++++
 tb/tb_conv_enc_framer_k3.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_enc_framer_k3.sv
// Rate-1/2, K=3 convolutional encoder with frame control: FRAME_LEN data bits followed by
// two zero tail bits per frame, one 2-bit symbol per transfer, marked with SOF/EOF.
//
// state | meaning
// IDLE  | waiting for the first data bit of a frame
// DATA  | accepting data bits; bit_ct holds the number already taken
// TAIL  | flushing two zero bits so the trellis ends in state 00
module conv_enc_framer_k3 #(
    parameter int         FRAME_LEN = 256,
    parameter logic [2:0] G0        = 3'b111,
    parameter logic [2:0] G1        = 3'b101,
    parameter int         CT_W      = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            enable_encoder_i,
    input  logic            encoder_i,
    input  logic            enc_valid_i,
    output logic            enc_ready_o,
    output logic [1:0]      sym_o,
    output logic            sym_valid_o,
    input  logic            sym_ready_i,
    output logic            sof_o,
    output logic            eof_o,
    output logic            busy_o,
    output logic [CT_W-1:0] frame_ct_o
);

    localparam int BC_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [BC_W-1:0] LAST_BIT = BC_W'(FRAME_LEN - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        TAIL = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        sr_q, sr_d;
    logic [BC_W-1:0]   bit_ct_q, bit_ct_d;
    logic              tail_ct_q, tail_ct_d;
    logic [1:0]        sym_q, sym_d;
    logic              sym_valid_q, sym_valid_d;
    logic              sof_q, sof_d;
    logic              eof_q, eof_d;
    logic [CT_W-1:0]   frame_ct_q, frame_ct_d;

    logic slot_free;
    logic accept;

    // Symbol is {c0, c1}; tap order is {current bit, sr[1], sr[0]}.
    function automatic logic [1:0] encode(input logic b, input logic [1:0] sr);
        encode = {^(G0 & {b, sr}), ^(G1 & {b, sr})};
    endfunction

    assign slot_free   = !sym_valid_q || sym_ready_i;
    assign enc_ready_o = !rst && enable_encoder_i && (state_q != TAIL) && slot_free;
    assign accept      = enc_valid_i && enc_ready_o;

    always_comb begin
        state_d     = state_q;
        sr_d        = sr_q;
        bit_ct_d    = bit_ct_q;
        tail_ct_d   = tail_ct_q;
        sym_d       = sym_q;
        sym_valid_d = sym_valid_q;
        sof_d       = sof_q;
        eof_d       = eof_q;
        frame_ct_d  = frame_ct_q;

        if (slot_free) begin
            sym_valid_d = 1'b0;
            sof_d       = 1'b0;
            eof_d       = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    sym_d       = encode(encoder_i, sr_q);
                    sym_valid_d = 1'b1;
                    sof_d       = 1'b1;
                    sr_d        = {encoder_i, sr_q[1]};
                    if (FRAME_LEN == 1) begin
                        state_d  = TAIL;
                        bit_ct_d = '0;
                    end else begin
                        state_d  = DATA;
                        bit_ct_d = BC_W'(1);
                    end
                end
            end
            DATA: begin
                if (accept) begin
                    sym_d       = encode(encoder_i, sr_q);
                    sym_valid_d = 1'b1;
                    sr_d        = {encoder_i, sr_q[1]};
                    if (bit_ct_q == LAST_BIT) begin
                        state_d  = TAIL;
                        bit_ct_d = '0;
                    end else begin
                        bit_ct_d = bit_ct_q + 1'b1;
                    end
                end
            end
            TAIL: begin
                if (slot_free) begin
                    sym_d       = encode(1'b0, sr_q);
                    sym_valid_d = 1'b1;
                    sr_d        = {1'b0, sr_q[1]};
                    if (tail_ct_q) begin
                        eof_d      = 1'b1;
                        frame_ct_d = frame_ct_q + 1'b1;
                        tail_ct_d  = 1'b0;
                        state_d    = IDLE;
                    end else begin
                        tail_ct_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            sr_q        <= 2'b00;
            bit_ct_q    <= '0;
            tail_ct_q   <= 1'b0;
            sym_q       <= 2'b00;
            sym_valid_q <= 1'b0;
            sof_q       <= 1'b0;
            eof_q       <= 1'b0;
            frame_ct_q  <= '0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            bit_ct_q    <= bit_ct_d;
            tail_ct_q   <= tail_ct_d;
            sym_q       <= sym_d;
            sym_valid_q <= sym_valid_d;
            sof_q       <= sof_d;
            eof_q       <= eof_d;
            frame_ct_q  <= frame_ct_d;
        end
    end

    assign sym_o       = sym_q;
    assign sym_valid_o = sym_valid_q;
    assign sof_o       = sof_q;
    assign eof_o       = eof_q;
    assign busy_o      = (state_q != IDLE);
    assign frame_ct_o  = frame_ct_q;

endmodule

// File: tb/tb_conv_enc_framer_k3.sv
// Bench for conv_enc_framer_k3: instance A (FRAME_LEN=4, CT_W=2) and instance B (FRAME_LEN=1),
// symbols checked against a convolution model computed directly from the generator taps.
module tb_conv_enc_framer_k3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       a_en, a_bit, a_vld, a_srdy, a_rdy, a_sv, a_sof, a_eof, a_busy;
    logic [1:0] a_sym, a_ct;
    logic       b_en, b_bit, b_vld, b_srdy, b_rdy, b_sv, b_sof, b_eof, b_busy;
    logic [1:0] b_sym;
    logic [15:0] b_ct;

    conv_enc_framer_k3 #(.FRAME_LEN(4), .CT_W(2)) u_a (
        .clk(clk), .rst(rst), .enable_encoder_i(a_en), .encoder_i(a_bit),
        .enc_valid_i(a_vld), .enc_ready_o(a_rdy), .sym_o(a_sym), .sym_valid_o(a_sv),
        .sym_ready_i(a_srdy), .sof_o(a_sof), .eof_o(a_eof), .busy_o(a_busy),
        .frame_ct_o(a_ct)
    );

    conv_enc_framer_k3 #(.FRAME_LEN(1), .CT_W(16)) u_b (
        .clk(clk), .rst(rst), .enable_encoder_i(b_en), .encoder_i(b_bit),
        .enc_valid_i(b_vld), .enc_ready_o(b_rdy), .sym_o(b_sym), .sym_valid_o(b_sv),
        .sym_ready_i(b_srdy), .sof_o(b_sof), .eof_o(b_eof), .busy_o(b_busy),
        .frame_ct_o(b_ct)
    );

    // sel picks which instance the stimulus and monitor talk to
    logic        sel;
    logic        o_rdy, o_sv, o_sof, o_eof, o_busy;
    logic [1:0]  o_sym;
    logic [15:0] o_ct;
    logic [4:0]  o_vec;
    assign o_rdy  = sel ? b_rdy  : a_rdy;
    assign o_sv   = sel ? b_sv   : a_sv;
    assign o_sof  = sel ? b_sof  : a_sof;
    assign o_eof  = sel ? b_eof  : a_eof;
    assign o_busy = sel ? b_busy : a_busy;
    assign o_sym  = sel ? b_sym  : a_sym;
    assign o_ct   = sel ? b_ct   : {14'd0, a_ct};
    assign o_vec  = {o_sv, o_sof, o_eof, o_sym};

    int n_cmp = 0;
    int n_err = 0;

    logic [3:0] exp_q[$];   // {c0, c1, sof, eof}
    logic       drv_q[$];
    logic       frm_q[$];
    int         mct[2];
    logic       stall_prev;
    logic [4:0] prev_obs;
    int         gaps;
    logic       seen;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_bits(input logic [31:0] v, input int n);
        for (int k = 0; k < n; k++) frm_q.push_back(v[n-1-k]);
    endtask

    // Output j of a rate-1/2 code is the mod-2 sum of g[2-t]*u[i-t]; u carries two zero tail bits.
    task automatic load_frame();
        logic       u[$];
        logic [2:0] g0, g1;
        int         s0, s1;
        g0 = 3'b111;
        g1 = 3'b101;
        u = frm_q;
        u.push_back(1'b0);
        u.push_back(1'b0);
        for (int i = 0; i < u.size(); i++) begin
            s0 = 0;
            s1 = 0;
            for (int t = 0; t < 3; t++) begin
                if (i - t >= 0) begin
                    s0 = s0 + ((g0[2-t] && u[i-t]) ? 1 : 0);
                    s1 = s1 + ((g1[2-t] && u[i-t]) ? 1 : 0);
                end
            end
            exp_q.push_back({(s0 % 2) == 1, (s1 % 2) == 1, i == 0, i == u.size() - 1});
        end
        foreach (frm_q[k]) drv_q.push_back(frm_q[k]);
        frm_q.delete();
    endtask

    task automatic cyc(input logic en, input logic vld, input logic bi, input logic srdy,
                       input logic rst_in, output logic acc);
        logic [3:0] e;
        int         idx;
        logic [31:0] mask;
        idx  = sel ? 1 : 0;
        mask = sel ? 32'hFFFF : 32'h3;
        rst  = rst_in;
        if (sel) begin
            b_en = en; b_vld = vld; b_bit = bi; b_srdy = srdy;
            a_en = 1'b0; a_vld = 1'b0; a_bit = 1'b0; a_srdy = 1'b1;
        end else begin
            a_en = en; a_vld = vld; a_bit = bi; a_srdy = srdy;
            b_en = 1'b0; b_vld = 1'b0; b_bit = 1'b0; b_srdy = 1'b1;
        end
        @(negedge clk);
        acc = vld && o_rdy;
        if (rst_in) chk("rdy_in_rst", o_rdy, 0);
        if (stall_prev) chk("hold", o_vec, prev_obs);
        if (o_sv && !srdy) chk("rdy_full", o_rdy, 0);
        if (o_sv) seen = 1'b1;
        if (seen && !o_sv && exp_q.size() > 0) gaps++;
        if (o_sv && srdy && !rst_in) begin
            chk("exp_avail", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("sym", o_sym, e[3:2]);
                chk("sof", o_sof, e[1]);
                chk("eof", o_eof, e[0]);
                if (e[0]) begin
                    mct[idx] = (mct[idx] + 1) & mask;
                    chk("frame_ct", o_ct, mct[idx]);
                end
            end
        end
        stall_prev = o_sv && !srdy && !rst_in;
        prev_obs   = o_vec;
        if (rst_in) begin
            mct[0] = 0;
            mct[1] = 0;
        end
        @(posedge clk);
        #1;
    endtask

    // srdy_mode: 0 always ready, 1 ready on odd cycles only, 2 random
    task automatic run(input int srdy_mode, input bit vrand, input int pause_at,
                       input int pause_len, input int budget, output int ncyc);
        int   acc_n, pause_cnt;
        logic en, vld, srdy, bi, acc;
        ncyc = 0;
        acc_n = 0;
        pause_cnt = 0;
        while ((drv_q.size() > 0 || exp_q.size() > 0) && ncyc < budget) begin
            en = 1'b1;
            if (acc_n >= pause_at && pause_cnt < pause_len) begin
                en = 1'b0;
                pause_cnt++;
            end
            case (srdy_mode)
                0:       srdy = 1'b1;
                1:       srdy = ncyc[0];
                default: srdy = 1'($urandom_range(0, 1));
            endcase
            vld = (drv_q.size() > 0) && (!vrand || ($urandom_range(0, 3) != 0));
            bi  = (drv_q.size() > 0) ? drv_q[0] : 1'b0;
            cyc(en, vld, bi, srdy, 1'b0, acc);
            if (!en) chk("pause_no_acc", acc, 0);
            if (acc) begin
                void'(drv_q.pop_front());
                acc_n++;
            end
            ncyc++;
        end
        chk("drained", (drv_q.size() == 0) && (exp_q.size() == 0), 1);
        drv_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int   nc, acc_n, k;
        logic acc;
        sel = 1'b0;
        rst = 1'b1;
        a_en = 0; a_vld = 0; a_bit = 0; a_srdy = 1;
        b_en = 0; b_vld = 0; b_bit = 0; b_srdy = 1;
        mct[0] = 0;
        mct[1] = 0;
        stall_prev = 1'b0;
        prev_obs = '0;
        gaps = 0;
        seen = 1'b0;

        cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, acc);
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, acc);
        chk("rst_a_out", {a_sv, a_sof, a_eof, a_busy, a_sym, a_ct}, 0);
        chk("rst_b_out", {b_sv, b_sof, b_eof, b_busy, b_sym, b_ct}, 0);

        // bits 1,0,1,1 with a free-running sink: 7 cycles including the first accept
        set_bits(32'b1011, 4);
        load_frame();
        run(0, 1'b0, 99, 0, 100, nc);
        chk("t1_cycles", nc, 7);
        chk("t1_busy", o_busy, 0);
        chk("t1_ct", o_ct, 1);

        set_bits(32'b1011, 4);
        load_frame();
        run(1, 1'b0, 99, 0, 100, nc);
        chk("t2_busy", o_busy, 0);

        set_bits(32'b1011, 4);
        load_frame();
        run(0, 1'b0, 2, 5, 100, nc);
        chk("t4_cycles", nc, 12);

        for (int f = 0; f < 3; f++) begin
            set_bits($urandom, 4);
            load_frame();
            run(2, 1'b1, 99, 0, 200, nc);
        end

        // abort after the third data bit; the pending third symbol must vanish
        set_bits(32'b0110, 4);
        load_frame();
        acc_n = 0;
        k = 0;
        while (acc_n < 3 && k < 20) begin
            cyc(1'b1, 1'b1, drv_q[0], 1'b1, 1'b0, acc);
            if (acc) begin
                void'(drv_q.pop_front());
                acc_n++;
            end
            k++;
        end
        chk("t5_accepts", acc_n, 3);
        cyc(1'b1, 1'b1, drv_q[0], 1'b0, 1'b1, acc);
        chk("t5_left", exp_q.size(), 4);
        chk("t5_out", {o_vec, o_busy}, 0);
        chk("t5_ct", o_ct, 0);
        exp_q.delete();
        drv_q.delete();
        set_bits(32'b1011, 4);
        load_frame();
        run(0, 1'b0, 99, 0, 100, nc);
        chk("t5_ct_after", o_ct, 1);

        // five back-to-back all-zero frames; count wraps through 3 -> 0
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, acc);
        gaps = 0;
        seen = 1'b0;
        for (int f = 0; f < 5; f++) begin
            set_bits(32'd0, 4);
            load_frame();
        end
        run(0, 1'b0, 99, 0, 200, nc);
        chk("t6_cycles", nc, 31);
        chk("t6_gaps", gaps, 0);
        chk("t6_ct", o_ct, 1);

        sel = 1'b1;
        set_bits(32'd1, 1);
        load_frame();
        run(0, 1'b0, 99, 0, 50, nc);
        chk("t3_cycles", nc, 4);
        chk("t3_busy", o_busy, 0);
        chk("t3_ct", o_ct, 1);
        for (int f = 0; f < 4; f++) begin
            set_bits($urandom, 1);
            load_frame();
            run(2, 1'b1, 99, 0, 100, nc);
        end
        chk("t3_busy_end", o_busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
